niios_qsys_ram_dp: RTL and testbench

- Parametrised true-dual-port on-chip RAM; successor to the single-port 32-bit x 5120 Qsys RAM.
- Two independent Avalon-MM slaves, s1 and s2, with configurable width, depth and read latency.
- Pipelined readdatavalid, waitrequest back-pressure, optional zero-fill after reset and deterministic write-collision rules.
- Sits on the Nios II data/instruction fabric as shared program/data memory, or as a CPU/DMA mailbox.

---
 rtl/niios_qsys_ram_dp_if.sv | 25 ++
 rtl/niios_qsys_ram_dp.sv | 177 +++++++++++++++++
 tb/tb_niios_qsys_ram_dp.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/niios_qsys_ram_dp_if.sv
// Avalon-MM slave bundle for one port of the dual-port RAM.
interface niios_qsys_ram_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/niios_qsys_ram_dp.sv
// True dual-port Avalon-MM RAM with zero-fill after reset and pipelined reads.
// Optional per-byte even parity storage is enabled by defining NIIOS_RAM_PARITY_EN.
module niios_qsys_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 5120,
    parameter int ADDR_WIDTH     = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  reset_req,
    niios_qsys_ram_dp_if.slave    s1,
    niios_qsys_ram_dp_if.slave    s2,
    output logic                  init_done,
    output logic [1:0]            parity_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic             en, stall, clr_we, clr_last;

    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][IDX_W-1:0]      idx;
    logic [1:0][NB-1:0]         be;
    logic [1:0][DATA_WIDTH-1:0] wd, rdata;
    logic [1:0]                 cs, rd, wr, rng, acc_wr, acc_rd, rvld, perr;

    logic [NB-1:0][7:0] mem [DEPTH];
`ifdef NIIOS_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = ^d[8*b +: 8];
        return r;
    endfunction
`endif

    assign en       = clken & ~reset_req;
    assign clr_last = (clr_idx == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  state <= ST_RESET;
        else if (en)   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: if (clr_last) state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    always_comb begin
        init_done = (state == ST_READY);
        clr_we    = (state == ST_CLEAR);
        stall     = (state != ST_READY) | ~en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              clr_idx <= '0;
        else if (en && clr_we)     clr_idx <= clr_last ? '0 : clr_idx + IDX_W'(1);
    end

    assign addr = {s2.address, s1.address};
    assign cs   = {s2.chipselect, s1.chipselect};
    assign rd   = {s2.read, s1.read};
    assign wr   = {s2.write, s1.write};
    assign be   = {s2.byteenable, s1.byteenable};
    assign wd   = {s2.writedata, s1.writedata};

    // A read paired with a write is dropped; the write still happens.
    assign acc_wr = cs & wr & {2{~stall}};
    assign acc_rd = cs & rd & ~wr & {2{~stall}};

    // s2 lanes are applied first so s1 overrides on lanes both ports enable.
    always_ff @(posedge clk) begin
        if (en && clr_we) begin
            mem[clr_idx] <= '0;
`ifdef NIIOS_RAM_PARITY_EN
            par_mem[clr_idx] <= '0;
`endif
        end else begin
            for (int p = 1; p >= 0; p--) begin
                for (int b = 0; b < NB; b++) begin
                    if (acc_wr[p] && rng[p] && be[p][b]) begin
                        mem[idx[p]][b] <= wd[p][8*b +: 8];
`ifdef NIIOS_RAM_PARITY_EN
                        par_mem[idx[p]][b] <= ^wd[p][8*b +: 8];
`endif
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] word, src_data, data_p1;
        logic                  err, src_vld, src_err, vld_p1, err_p1;

        assign rng[p] = ({1'b0, addr[p]} < (ADDR_WIDTH+1)'(DEPTH));
        assign idx[p] = addr[p][IDX_W-1:0];

        always_comb begin
            word = '0;
            err  = 1'b0;
            if (rng[p]) begin
                word = mem[idx[p]];
`ifdef NIIOS_RAM_PARITY_EN
                err  = |(byte_parity(mem[idx[p]]) ^ par_mem[idx[p]]);
`endif
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] data_p0;
            logic                  vld_p0, err_p0;

            // Stage p0: capture the addressed word at acceptance
            always_ff @(posedge clk) begin
                if (acc_rd[p]) begin
                    data_p0 <= word;
                    err_p0  <= err;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) vld_p0 <= 1'b0;
                else if (en)  vld_p0 <= acc_rd[p];
            end

            assign src_data = data_p0;
            assign src_vld  = vld_p0;
            assign src_err  = err_p0;
        end else begin : g_lat1
            assign src_data = word;
            assign src_vld  = acc_rd[p];
            assign src_err  = err;
        end

        // Stage p1: output register; readdata holds between beats
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
                err_p1  <= 1'b0;
            end else if (en) begin
                vld_p1 <= src_vld;
                if (src_vld) begin
                    data_p1 <= src_data;
                    err_p1  <= src_err;
                end
            end
        end

        // A beat counts as delivered only in an enabled cycle, so a freeze never repeats it.
        assign rdata[p] = data_p1;
        assign rvld[p]  = vld_p1 & en;
        assign perr[p]  = vld_p1 & err_p1 & en;
    end

    assign s1.readdata      = rdata[0];
    assign s1.readdatavalid = rvld[0];
    assign s1.waitrequest   = stall;
    assign s2.readdata      = rdata[1];
    assign s2.readdatavalid = rvld[1];
    assign s2.waitrequest   = stall;
    assign parity_err       = perr;
endmodule

// File: tb/tb_niios_qsys_ram_dp.sv
// Randomised bench for niios_qsys_ram_dp against a transaction-level memory model.
module tb_niios_qsys_ram_dp;
    localparam int DW = 32, AW = 5, DEPTH = 16, LAT = 2, NB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, clken, reset_req, init_done;
    logic [1:0] parity_err;

    niios_qsys_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_bus();
    niios_qsys_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_bus();

    niios_qsys_ram_dp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1(s1_bus), .s2(s2_bus), .init_done(init_done), .parity_err(parity_err)
    );

    typedef struct { int due; logic [DW-1:0] data; logic err; } beat_t;

    logic [AW-1:0] t_addr [2];
    logic          t_cs [2], t_rd [2], t_wr [2];
    logic [NB-1:0] t_be [2];
    logic [DW-1:0] t_wd [2];
    logic          t_clken, t_rreq, t_rstn;

    logic [DW-1:0] mdl [DEPTH];
    logic [NB-1:0] mdl_bad [DEPTH];
    beat_t         q0[$], q1[$];
    logic [DW-1:0] hold0, hold1;
    int            init_cnt, ecnt;
    int            checks = 0, errors = 0, cyc_n = 0;

    int            l1_cyc[$], l2_cyc[$];
    logic [DW-1:0] l1_dat[$], l2_dat[$];
    logic [1:0]    l2_pe[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic port_chk(input string nm, ref beat_t q[$], ref logic [DW-1:0] hold,
                            input logic en, input logic [DW-1:0] rdat, input logic rv,
                            input logic pe);
        logic          cur, epe;
        logic [DW-1:0] ed;
        while (q.size() > 0 && q[0].due < ecnt) begin
            hold = q[0].data;
            void'(q.pop_front());
        end
        cur = (q.size() > 0) && (q[0].due == ecnt);
        ed  = hold;
        epe = 1'b0;
        if (cur) begin
            ed  = q[0].data;
            epe = en & q[0].err;
        end
        chk({nm, "_readdata"}, rdat, ed);
        chk({nm, "_readdatavalid"}, rv, cur & en);
        chk({nm, "_parity_err"}, pe, epe);
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            t_cs[p] = 1'b0; t_rd[p] = 1'b0; t_wr[p] = 1'b0;
        end
    endtask

    task automatic do_rd(input int p, input int a);
        t_cs[p] = 1'b1; t_rd[p] = 1'b1; t_wr[p] = 1'b0; t_addr[p] = AW'(a);
    endtask

    task automatic do_wr(input int p, input int a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        t_cs[p] = 1'b1; t_rd[p] = 1'b0; t_wr[p] = 1'b1; t_addr[p] = AW'(a);
        t_wd[p] = d; t_be[p] = b;
    endtask

    task automatic clear_logs();
        l1_cyc.delete(); l1_dat.delete(); l2_cyc.delete(); l2_dat.delete(); l2_pe.delete();
    endtask

    // One bus cycle: drive, check against the model, then advance the model.
    task automatic step();
        logic  en, ready;
        int    a;
        beat_t bt;
        @(negedge clk);
        reset_n = t_rstn; clken = t_clken; reset_req = t_rreq;
        s1_bus.address = t_addr[0]; s1_bus.chipselect = t_cs[0]; s1_bus.read = t_rd[0];
        s1_bus.write = t_wr[0]; s1_bus.byteenable = t_be[0]; s1_bus.writedata = t_wd[0];
        s2_bus.address = t_addr[1]; s2_bus.chipselect = t_cs[1]; s2_bus.read = t_rd[1];
        s2_bus.write = t_wr[1]; s2_bus.byteenable = t_be[1]; s2_bus.writedata = t_wd[1];
        #1;
        cyc_n++;
        if (!t_rstn) begin
            q0.delete(); q1.delete(); hold0 = '0; hold1 = '0; init_cnt = 0; ecnt = 0;
            for (int i = 0; i < DEPTH; i++) begin mdl[i] = '0; mdl_bad[i] = '0; end
        end
        en    = t_clken & ~t_rreq;
        ready = t_rstn && (init_cnt >= 1 + DEPTH);
        chk("s1_waitrequest", s1_bus.waitrequest, !ready || !en);
        chk("s2_waitrequest", s2_bus.waitrequest, !ready || !en);
        chk("init_done", init_done, ready);
        port_chk("s1", q0, hold0, en, s1_bus.readdata, s1_bus.readdatavalid, parity_err[0]);
        port_chk("s2", q1, hold1, en, s2_bus.readdata, s2_bus.readdatavalid, parity_err[1]);
        if (s1_bus.readdatavalid === 1'b1) begin
            l1_cyc.push_back(cyc_n); l1_dat.push_back(s1_bus.readdata);
        end
        if (s2_bus.readdatavalid === 1'b1) begin
            l2_cyc.push_back(cyc_n); l2_dat.push_back(s2_bus.readdata); l2_pe.push_back(parity_err);
        end
        if (t_rstn && en) begin
            if (ready) begin
                for (int p = 0; p < 2; p++) begin
                    if (t_cs[p] && t_rd[p] && !t_wr[p]) begin
                        a       = int'(t_addr[p]);
                        bt.due  = ecnt + LAT;
                        bt.data = (a < DEPTH) ? mdl[a] : '0;
                        bt.err  = (a < DEPTH) ? |mdl_bad[a] : 1'b0;
                        if (p == 0) q0.push_back(bt); else q1.push_back(bt);
                    end
                end
                for (int p = 1; p >= 0; p--) begin
                    a = int'(t_addr[p]);
                    if (t_cs[p] && t_wr[p] && a < DEPTH) begin
                        for (int b = 0; b < NB; b++) begin
                            if (t_be[p][b]) begin
                                mdl[a][8*b +: 8] = t_wd[p][8*b +: 8];
                                mdl_bad[a][b]    = 1'b0;
                            end
                        end
                    end
                end
            end
            if (init_cnt < 1 + DEPTH) init_cnt++;
            ecnt++;
        end
    endtask

    initial begin
        int n, r;
        logic seen;
        t_rstn = 1'b0; t_clken = 1'b1; t_rreq = 1'b0;
        for (int p = 0; p < 2; p++) begin
            t_addr[p] = '0; t_be[p] = '0; t_wd[p] = '0;
        end
        idle();
        repeat (3) step();

        // Release reset and count cycles until the memory becomes usable.
        t_rstn = 1'b1;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (init_done === 1'b1) seen = 1'b1; else n++;
        end
        chk("init_cycles", n, 17);

        for (int a = 0; a < DEPTH; a++) begin
            do_rd(0, a); do_rd(1, DEPTH - 1 - a); step();
        end
        idle(); repeat (3) step();

        // Latency-2 write then three back-to-back reads.
        clear_logs();
        do_wr(0, 5, 32'hDEADBEEF, 4'hF); step();
        do_rd(0, 5); step(); r = cyc_n;
        do_rd(0, 6); step();
        do_rd(0, 5); step();
        idle(); repeat (4) step();
        chk("lat_beats", l1_cyc.size(), 3);
        if (l1_cyc.size() >= 3) begin
            chk("lat_cyc0", l1_cyc[0] - r, 2);
            chk("lat_cyc1", l1_cyc[1] - r, 3);
            chk("lat_cyc2", l1_cyc[2] - r, 4);
            chk("lat_dat0", l1_dat[0], 32'hDEADBEEF);
            chk("lat_dat1", l1_dat[1], 32'h0);
            chk("lat_dat2", l1_dat[2], 32'hDEADBEEF);
        end

        // Same-address write collision, then read-during-write on the other port.
        do_wr(0, 7, 32'h11223344, 4'b0011); do_wr(1, 7, 32'hAABBCCDD, 4'b0110); step();
        idle(); step();
        chk("mdl_collision", mdl[7], 32'h00BB3344);
        clear_logs();
        do_rd(1, 7); do_wr(0, 7, 32'hFFFFFFFF, 4'hF); step();
        idle(); do_rd(1, 7); step();
        idle(); repeat (4) step();
        chk("rdw_beats", l2_dat.size(), 2);
        if (l2_dat.size() >= 2) begin
            chk("rdw_old", l2_dat[0], 32'h00BB3344);
            chk("rdw_new", l2_dat[1], 32'hFFFFFFFF);
        end

        // Freeze with two reads in flight.
        clear_logs();
        do_rd(0, 5); step(); r = cyc_n;
        do_rd(0, 6); step();
        idle(); t_clken = 1'b0; repeat (3) step();
        t_clken = 1'b1; repeat (4) step();
        chk("frz_beats", l1_cyc.size(), 2);
        if (l1_cyc.size() >= 2) begin
            chk("frz_cyc0", l1_cyc[0] - r, 5);
            chk("frz_cyc1", l1_cyc[1] - r, 6);
            chk("frz_dat0", l1_dat[0], 32'hDEADBEEF);
            chk("frz_dat1", l1_dat[1], 32'h0);
        end

        clear_logs();
        do_rd(0, DEPTH + 1); step(); r = cyc_n;
        idle(); repeat (3) step();
        chk("oob_beats", l1_cyc.size(), 1);
        if (l1_cyc.size() >= 1) begin
            chk("oob_cyc", l1_cyc[0] - r, 2);
            chk("oob_dat", l1_dat[0], 32'h0);
        end

`ifdef NIIOS_RAM_PARITY_EN
        dut.par_mem[3][0] = ~dut.par_mem[3][0];
        mdl_bad[3][0] = 1'b1;
        clear_logs();
        do_rd(1, 3); step();
        idle(); repeat (3) step();
        chk("par_beats", l2_pe.size(), 1);
        if (l2_pe.size() >= 1) chk("par_err", l2_pe[0], 2'b10);
`endif

        // Random traffic with clock-enable gaps, reset requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            t_rstn  = ($urandom_range(0, 599) != 0);
            t_clken = ($urandom_range(0, 9) != 0);
            t_rreq  = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < 2; p++) begin
                t_cs[p]   = ($urandom_range(0, 3) != 0);
                t_rd[p]   = $urandom_range(0, 1) == 1;
                t_wr[p]   = ($urandom_range(0, 2) == 0);
                t_addr[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                                        : AW'($urandom_range(0, 31));
                t_be[p]   = NB'($urandom);
                t_wd[p]   = $urandom;
            end
            step();
        end
        t_rstn = 1'b1; t_clken = 1'b1; t_rreq = 1'b0;
        idle(); repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
